// File: rtl/display_scan.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Presents one nibble per digit slot; value updates take effect only at frame start.
module display_scan #(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*NDIG-1:0]   value,
    input  logic                blank_lz,
    output logic [3:0]          D,
    output logic [NDIG-1:0]     AN,
    output logic                frame
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (NDIG > 2) ? $clog2(NDIG) : 1;
    localparam int unsigned VW = 4 * NDIG;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [VW-1:0] shadow;
    logic [VW-1:0] pend;
    logic          pend_v;

    logic          adv_c;
    logic          last_c;
    logic          wrap_c;
    logic [IW-1:0] idx_nxt_c;
    logic [VW-1:0] shadow_nxt_c;
    logic          blank_c;

    // Next digit, next displayed value and blanking of the digit about to be shown
    always_comb begin
        adv_c        = (cnt == CW'(REFRESH_DIV - 1));
        last_c       = (idx == IW'(NDIG - 1));
        wrap_c       = adv_c && last_c;
        idx_nxt_c    = idx;
        shadow_nxt_c = shadow;
        if (adv_c) begin
            idx_nxt_c = last_c ? '0 : idx + IW'(1);
        end
        if (wrap_c) begin
            if (load) begin
                shadow_nxt_c = value;
            end else if (pend_v) begin
                shadow_nxt_c = pend;
            end
        end
        blank_c = blank_lz && (idx_nxt_c != '0);
        for (int j = 0; j < NDIG; j++) begin
            if ((IW'(j) >= idx_nxt_c) && (shadow_nxt_c[4*j +: 4] != 4'h0)) begin
                blank_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            D      <= 4'h0;
            AN     <= ~NDIG'(1);
            frame  <= 1'b0;
        end else begin
            cnt    <= adv_c ? '0 : cnt + CW'(1);
            idx    <= idx_nxt_c;
            shadow <= shadow_nxt_c;
            frame  <= wrap_c;
            if (wrap_c) begin
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= value;
                pend_v <= 1'b1;
            end
            // Outputs move only on digit-advance edges so a digit is never torn
            if (adv_c) begin
                D  <= shadow_nxt_c[{idx_nxt_c, 2'b00} +: 4];
                AN <= blank_c ? '1 : ~(NDIG'(1) << idx_nxt_c);
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan (NDIG=4, REFRESH_DIV=4) with a time-based
// reference model compared every cycle plus hand-computed literal checks.
module tb_display_scan;

    localparam int unsigned NDIG = 4;
    localparam int unsigned RD   = 4;
    localparam int unsigned FLEN = NDIG * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  D;
    logic [3:0]  AN;
    logic        frame;

    display_scan #(.NDIG(NDIG), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .D        (D),
        .AN       (AN),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          n;
    logic [15:0] m_shadow;
    logic [15:0] m_pval;
    bit          m_pv;
    logic [3:0]  e_d;
    logic [3:0]  e_an;
    logic        e_frame;
    bit          chk = 1'b0;

    // Model: n edges since reset; frames start every FLEN edges, digits every RD edges
    task automatic model_update();
        int dg;
        if (rst) begin
            n        = 0;
            m_shadow = 16'h0;
            m_pv     = 1'b0;
            e_d      = 4'h0;
            e_an     = 4'b1110;
            e_frame  = 1'b0;
        end else begin
            n++;
            e_frame = ((n % FLEN) == 0);
            if (e_frame) begin
                if (load) m_shadow = value;
                else if (m_pv) m_shadow = m_pval;
                m_pv = 1'b0;
            end else if (load) begin
                m_pv   = 1'b1;
                m_pval = value;
            end
            if ((n % RD) == 0) begin
                dg   = (n / RD) % NDIG;
                e_d  = 4'((m_shadow >> (4 * dg)) & 16'hF);
                e_an = (blank_lz && dg > 0 && (m_shadow >> (4 * dg)) == 16'h0)
                       ? 4'hF : ~(4'b0001 << dg);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_to(input int k);
        while (n < k) tick();
    endtask

    task automatic pulse(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at n=%0d: got %b, required %b", nm, n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            total++;
            if (D !== e_d || AN !== e_an || frame !== e_frame) begin
                bad++;
                $display("FAIL model n=%0d: got D=%h AN=%b frame=%b, required D=%h AN=%b frame=%b",
                         n, D, AN, frame, e_d, e_an, e_frame);
            end
        end
    end

    initial begin
        rst = 1'b1; load = 1'b0; value = 16'h0; blank_lz = 1'b0; n = 0;
        // Reset
        tick(); chk = 1'b1;
        tick(); tick();
        lit("rst_D", D, 4'h0);
        lit("rst_AN", AN, 4'b1110);
        lit("rst_frame", {3'b000, frame}, 4'h0);
        rst = 1'b0;
        run_to(3);
        lit("pre_adv_AN", AN, 4'b1110);
        run_to(4);
        lit("adv_AN", AN, 4'b1101);
        lit("adv_D", D, 4'h0);

        // Normal scan: load at idx=3 on a non-wrap edge
        run_to(12); pulse(16'h1234);
        run_to(16);
        lit("scan_frame", {3'b000, frame}, 4'h1);
        lit("scan_D0", D, 4'h4);
        lit("scan_AN0", AN, 4'b1110);
        tick();
        lit("scan_frame_off", {3'b000, frame}, 4'h0);
        run_to(20); lit("scan_D1", D, 4'h3); lit("scan_AN1", AN, 4'b1101);
        run_to(24); lit("scan_D2", D, 4'h2); lit("scan_AN2", AN, 4'b1011);
        run_to(28); lit("scan_D3", D, 4'h1); lit("scan_AN3", AN, 4'b0111);

        // Leading-zero blanking
        run_to(30); pulse(16'h0050); blank_lz = 1'b1;
        run_to(32); lit("blk_D0", D, 4'h0); lit("blk_AN0", AN, 4'b1110);
        run_to(36); lit("blk_D1", D, 4'h5); lit("blk_AN1", AN, 4'b1101);
        run_to(40); lit("blk_AN2", AN, 4'b1111); lit("blk_D2", D, 4'h0);
        run_to(44); lit("blk_AN3", AN, 4'b1111);
        pulse(16'h0000);
        run_to(48); lit("zero_D0", D, 4'h0); lit("zero_AN0", AN, 4'b1110);
        run_to(52); lit("zero_AN1", AN, 4'b1111);

        // Tear-free update
        run_to(60); blank_lz = 1'b0; pulse(16'h1234);
        run_to(64); lit("tear_D0", D, 4'h4);
        run_to(68); pulse(16'hABCD);
        run_to(72); lit("tear_D2", D, 4'h2); lit("tear_AN2", AN, 4'b1011);
        run_to(76); lit("tear_D3", D, 4'h1);
        run_to(80); lit("new_D0", D, 4'hD);
        run_to(84); lit("new_D1", D, 4'hC);
        run_to(88); lit("new_D2", D, 4'hB);
        run_to(92); lit("new_D3", D, 4'hA);

        // Load collisions
        run_to(96); pulse(16'h1111);
        run_to(100); pulse(16'h2222);
        run_to(112); lit("last_wins_D0", D, 4'h2);
        run_to(124); lit("last_wins_D3", D, 4'h2);
        run_to(127); pulse(16'h3333);
        lit("wrap_load_D0", D, 4'h3);
        lit("wrap_load_frame", {3'b000, frame}, 4'h1);

        // Reset mid-frame with a pending value and a simultaneous load
        run_to(132); pulse(16'h5555);
        run_to(137);
        rst = 1'b1; load = 1'b1; value = 16'h9999;
        tick();
        lit("mid_rst_D", D, 4'h0);
        lit("mid_rst_AN", AN, 4'b1110);
        lit("mid_rst_frame", {3'b000, frame}, 4'h0);
        rst = 1'b0; load = 1'b0;
        run_to(16);
        lit("post_rst_frame", {3'b000, frame}, 4'h1);
        lit("post_rst_D0", D, 4'h0);
        run_to(20); lit("post_rst_D1", D, 4'h0); lit("post_rst_AN1", AN, 4'b1101);
        run_to(34);

        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
